atm_keypad_frontend: RTL
========================

Name: atm_keypad_frontend

Overview:
- Upstream stage of the ATM controller. Debounces raw key events from the keypad decoder.
- In PIN mode it emits one-cycle digit strobes carrying a BCD digit.
- In amount mode it accumulates decimal digits into a 32-bit binary amount and emits a one-cycle amount strobe when the user presses ENTER.
- Its digit and amount outputs connect directly to the controller's digit/digit-strobe and amount/amount-strobe inputs.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles a key level must be stable before press or release is accepted; legal range 2..255.
- MAX_DIGITS, 9, maximum amount digits accepted; 9 guarantees the result fits in 32 bits.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- key_valid  input  1  raw level: a key is currently pressed
- key_code  input  4  raw code: 0-9 digit, 0xA CLEAR, 0xB ENTER, 0xC BACKSPACE, 0xD-0xF unused
- amount_mode  input  1  0 = PIN entry, 1 = amount entry
- digito_stb  output  1  one-cycle pulse: a PIN digit was accepted
- digito  output  4  BCD digit; valid while digito_stb is high, held otherwise
- monto_stb  output  1  one-cycle pulse: amount confirmed
- monto  output  32  binary amount; updated with monto_stb, held until the next monto_stb
- key_rejected  output  1  one-cycle pulse: an accepted key had no effect

Behaviour:
- Reset: all outputs 0, accumulator 0, digit count 0, FSM IDLE, debounce counter 0. Reset mid-press returns the FSM to IDLE, so a key still held after reset must be seen stable for DEBOUNCE_CYCLES again and is accepted once.
- Debounce FSM, 8-bit counter cnt:
  - IDLE: key_valid=1 → capture key_code, cnt=1, go to DEBOUNCE.
  - DEBOUNCE: key_valid=0 or key_code≠captured → IDLE, cnt=0. Otherwise, cnt==DEBOUNCE_CYCLES-1 → accept the key, go to HELD. Otherwise cnt++.
  - HELD: key_valid=0 → cnt=1, go to RELEASE. Code changes while held are ignored.
  - RELEASE: key_valid=1 → HELD (bounce). Otherwise, cnt==DEBOUNCE_CYCLES-1 → IDLE. Otherwise cnt++.
- Exactly one accept per press.
- Latency: if key_valid is first sampled high at edge N, the accept occurs at edge N+DEBOUNCE_CYCLES-1 and the strobe is high during the cycle after edge N+DEBOUNCE_CYCLES-1. All outputs are registered.
- PIN mode, on accept:
  - Digit key: digito=code, digito_stb=1.
  - Any other key: key_rejected=1.
  - The accumulator is not touched.
- Amount mode, on accept:
  - Digit with count<MAX_DIGITS: acc = acc*10 + code. Compute as (acc<<3)+(acc<<1)+code in 32 bits. count++.
  - Digit with count==MAX_DIGITS: key_rejected=1, acc unchanged.
  - CLEAR: acc=0, count=0.
  - BACKSPACE: count>0 → acc=acc/10, count--. count==0 → key_rejected=1. Implement the divide by 10 as constant-divisor combinational logic.
  - ENTER: count>0 → monto=acc, monto_stb=1, acc=0, count=0. count==0 → key_rejected=1, no strobe.
  - Unused codes: key_rejected=1.
- A change of amount_mode, detected from a registered copy, clears acc and count in that cycle. If an accept happens in the same cycle, the new mode applies and the accept operates on the cleared accumulator.
- digito_stb and monto_stb are never high in the same cycle.
- Strobes never last more than 1 cycle, even if the key is held.

Decomposition:
- Shared package atm_pkg:
  - Key-code constants KEY_CLEAR=4'hA, KEY_ENTER=4'hB, KEY_BKSP=4'hC.
  - Debounce state encoding: IDLE/DEBOUNCE/HELD/RELEASE.
  - Bus widths: DIGIT_W=4, AMOUNT_W=32.
- One sub-module: key_debouncer. It contains the FSM and counter and outputs key_accept (pulse) and key_code_q.
- The top level holds the mode logic, the accumulator and the output registers.

Test Plan (DEBOUNCE_CYCLES=4):
- PIN mode, press 4,7,5,6, each held 6 cycles with 6-cycle gaps → four digito_stb pulses with digito 4,7,5,6; each pulse appears 4 cycles after the first high sample; no monto_stb.
- Bounce: key_valid high 2 cycles, low 1, high 6 → exactly one accept, 4 cycles after the final rise. Release bounce (low 2, high 1, low 5) → no second accept.
- Amount mode, press 1,5,0,0,ENTER → monto_stb=1 for 1 cycle with monto=1500; the next ENTER gives key_rejected=1 and monto stays 1500.
- Amount mode, press 9 ten times then ENTER → the tenth digit gives key_rejected; monto=999999999. Press 1,2,BACKSPACE,3,ENTER → monto=13.
- Press 4,2,CLEAR,7,ENTER → monto=7. Press 3, then toggle amount_mode to 0 and back to 1, then ENTER → key_rejected, no monto_stb.
- Assert rst while a key is held mid-debounce → all outputs 0. Keep the key held 4 more cycles after reset release → one accept; no strobe in the cycles during reset.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM keypad front end: key codes, widths,
// debounce state encoding and the constant-multiply/divide helpers.
package atm_pkg;

    localparam int DIGIT_W  = 4;
    localparam int AMOUNT_W = 32;

    localparam logic [DIGIT_W-1:0] KEY_CLEAR = 4'hA;
    localparam logic [DIGIT_W-1:0] KEY_ENTER = 4'hB;
    localparam logic [DIGIT_W-1:0] KEY_BKSP  = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } deb_state_e;

    function automatic logic is_digit(input logic [DIGIT_W-1:0] code);
        return (code <= 4'd9);
    endfunction

    // acc*10 + digit, wrapping in 32 bits
    function automatic logic [AMOUNT_W-1:0] mul10_add(input logic [AMOUNT_W-1:0] acc,
                                                      input logic [DIGIT_W-1:0]  digit);
        return (acc << 3) + (acc << 1) + {{(AMOUNT_W-DIGIT_W){1'b0}}, digit};
    endfunction

    // floor(x/10) by reciprocal multiply; exact for every 32-bit x
    function automatic logic [AMOUNT_W-1:0] div10(input logic [AMOUNT_W-1:0] x);
        logic [63:0] prod;
        prod = {32'd0, x} * 64'h0000_0000_CCCC_CCCD;
        return {3'd0, prod[63:35]};
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Debounce FSM: accepts a key once after it is stable for DEBOUNCE_CYCLES,
// then requires a stable release of the same length before re-arming.
//
// state    | meaning
// IDLE     | no key seen, waiting for key_valid
// DEBOUNCE | counting stable samples of the captured code
// HELD     | key accepted, waiting for release
// RELEASE  | counting stable released samples
module key_debouncer
    import atm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_code,
    output logic               key_accept,
    output logic [DIGIT_W-1:0] key_code_q
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    deb_state_e         state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [DIGIT_W-1:0] code_q, code_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        key_accept = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    code_d  = key_code;
                    cnt_d   = 8'd1;
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (!key_valid || (key_code != code_q)) begin
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    key_accept = 1'b1;
                    state_d    = ST_HELD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_HELD: begin
                // code changes while held are deliberately ignored
                if (!key_valid) begin
                    cnt_d   = 8'd1;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (key_valid) begin
                    state_d = ST_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign key_code_q = code_q;

endmodule

// File: rtl/atm_keypad_frontend.sv
// Keypad front end: debounced keys become PIN digit strobes or, in amount
// mode, a decimal accumulator confirmed with ENTER.
module atm_keypad_frontend
    import atm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_DIGITS      = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    input  logic [DIGIT_W-1:0]  key_code,
    input  logic                amount_mode,
    output logic                digito_stb,
    output logic [DIGIT_W-1:0]  digito,
    output logic                monto_stb,
    output logic [AMOUNT_W-1:0] monto,
    output logic                key_rejected
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

    logic               key_accept;
    logic [DIGIT_W-1:0] acc_code;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_accept(key_accept),
        .key_code_q(acc_code)
    );

    logic                mode_q, mode_d;
    logic [AMOUNT_W-1:0] acc_q, acc_d, acc_base;
    logic [CNT_W-1:0]    count_q, count_d, count_base;
    logic                digito_stb_q, digito_stb_d;
    logic [DIGIT_W-1:0]  digito_q, digito_d;
    logic                monto_stb_q, monto_stb_d;
    logic [AMOUNT_W-1:0] monto_q, monto_d;
    logic                rej_q, rej_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= 1'b0;
            acc_q        <= '0;
            count_q      <= '0;
            digito_stb_q <= 1'b0;
            digito_q     <= '0;
            monto_stb_q  <= 1'b0;
            monto_q      <= '0;
            rej_q        <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            digito_stb_q <= digito_stb_d;
            digito_q     <= digito_d;
            monto_stb_q  <= monto_stb_d;
            monto_q      <= monto_d;
            rej_q        <= rej_d;
        end
    end

    always_comb begin
        mode_d       = amount_mode;
        digito_stb_d = 1'b0;
        digito_d     = digito_q;
        monto_stb_d  = 1'b0;
        monto_d      = monto_q;
        rej_d        = 1'b0;

        // a mode change wipes the amount before any same-cycle key acts on it
        if (amount_mode != mode_q) begin
            acc_base   = '0;
            count_base = '0;
        end else begin
            acc_base   = acc_q;
            count_base = count_q;
        end
        acc_d   = acc_base;
        count_d = count_base;

        if (key_accept) begin
            if (!amount_mode) begin
                if (is_digit(acc_code)) begin
                    digito_d     = acc_code;
                    digito_stb_d = 1'b1;
                end else begin
                    rej_d = 1'b1;
                end
            end else if (is_digit(acc_code)) begin
                if (count_base < CNT_MAX) begin
                    acc_d   = mul10_add(acc_base, acc_code);
                    count_d = count_base + 1'b1;
                end else begin
                    rej_d = 1'b1;
                end
            end else begin
                unique case (acc_code)
                    KEY_CLEAR: begin
                        acc_d   = '0;
                        count_d = '0;
                    end
                    KEY_BKSP: begin
                        if (count_base != '0) begin
                            acc_d   = div10(acc_base);
                            count_d = count_base - 1'b1;
                        end else begin
                            rej_d = 1'b1;
                        end
                    end
                    KEY_ENTER: begin
                        if (count_base != '0) begin
                            monto_d     = acc_base;
                            monto_stb_d = 1'b1;
                            acc_d       = '0;
                            count_d     = '0;
                        end else begin
                            rej_d = 1'b1;
                        end
                    end
                    default: rej_d = 1'b1;
                endcase
            end
        end
    end

    assign digito_stb   = digito_stb_q;
    assign digito       = digito_q;
    assign monto_stb    = monto_stb_q;
    assign monto        = monto_q;
    assign key_rejected = rej_q;

endmodule
